// File: rtl/peak_frame_receiver_pkg.sv
// Shared definitions for the peak frame receiver: marker bytes, FSM state
// encoding, word/index types and the largest word value a frame can carry.
package peak_frame_receiver_pkg;

    typedef logic [15:0] word_t;
    typedef logic [8:0]  index_t;

    localparam logic [7:0] MARK_BYTE  = 8'hFF;
    localparam logic [7:0] START_CODE = 8'h20;
    localparam logic [7:0] STOP_CODE  = 8'h80;

    // Largest value a data word can take (255*255); a high byte of FF never
    // occurs in data, which keeps markers unambiguous.
    localparam word_t PEAK_CEIL = 16'hFE01;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        SYNC    = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        MARK    = 3'd4
    } state_e;

endpackage

// File: rtl/peak_rx_max_tracker.sv
// Running maximum of the words of the current frame. The running value is
// cleared at frame start and published on commit (a valid stop marker).
// Ties keep the earliest index because only a strictly larger word replaces
// the running maximum.
module peak_rx_max_tracker
    import peak_frame_receiver_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clear_i,
    input  logic   word_valid_i,
    input  word_t  word_i,
    input  index_t index_i,
    input  logic   commit_i,
    output word_t  max_word_o,
    output index_t max_index_o
);

    word_t  run_max_q;
    index_t run_idx_q;
    word_t  max_word_q;
    index_t max_index_q;
    logic   at_ceil;

    // Once the running max sits at the ceiling nothing in the frame can beat it.
    assign at_ceil = (run_max_q == PEAK_CEIL);

    // Running maximum over the words of the frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max_q <= '0;
            run_idx_q <= '0;
        end else if (clear_i) begin
            run_max_q <= '0;
            run_idx_q <= '0;
        end else if (word_valid_i && !at_ceil && (word_i > run_max_q)) begin
            run_max_q <= word_i;
            run_idx_q <= index_i;
        end
    end

    // Published result, held until the next completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_word_q  <= '0;
            max_index_q <= '0;
        end else if (commit_i) begin
            max_word_q  <= run_max_q;
            max_index_q <= run_idx_q;
        end
    end

    assign max_word_o  = max_word_q;
    assign max_index_o = max_index_q;

endmodule

// File: rtl/peak_frame_receiver.sv
// Peak frame receiver: finds FF,START markers in a byte stream, rebuilds
// 16-bit words from hi/lo byte pairs, and closes the frame on FF,STOP.
// Build option: define PEAK_RX_MAXTRACK_EN to report the largest word of each
// completed frame on MaxWord/MaxIndex; otherwise those outputs are tied to 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | waiting for a marker byte FF
// SYNC    | seen FF, expecting START_CODE
// DATA_HI | expecting a word high byte or the FF of a marker
// DATA_LO | high byte latched, expecting the low byte
// MARK    | FF seen inside a frame, expecting STOP_CODE (or a restart)
module peak_frame_receiver
    import peak_frame_receiver_pkg::*;
#(
    parameter int         MAX_WORDS  = 256,
    parameter logic [7:0] START_CODE = peak_frame_receiver_pkg::START_CODE,
    parameter logic [7:0] STOP_CODE  = peak_frame_receiver_pkg::STOP_CODE
) (
    input  logic        SysClk,
    input  logic        ResetN,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic [15:0] WordOut,
    output logic        WordValid,
    output logic [8:0]  WordIndex,
    output logic        FrameDone,
    output logic [8:0]  FrameCount,
    output logic        FrameError,
    output logic [15:0] MaxWord,
    output logic [8:0]  MaxIndex
);

    localparam index_t MAX_CNT = index_t'(MAX_WORDS);

    state_e state_q;
    index_t count_q;
    logic [7:0] hi_q;
    word_t  word_out_q;
    index_t word_index_q;
    logic   word_valid_q;
    logic   frame_done_q;
    logic   frame_error_q;
    index_t frame_count_q;

    // Protocol FSM with registered word/frame outputs; pulses last one cycle.
    always_ff @(posedge SysClk or negedge ResetN) begin
        if (!ResetN) begin
            state_q       <= HUNT;
            count_q       <= '0;
            hi_q          <= '0;
            word_out_q    <= '0;
            word_index_q  <= '0;
            word_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            word_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            if (RxValid) begin
                case (state_q)
                    HUNT: begin
                        if (RxData == MARK_BYTE) state_q <= SYNC;
                    end
                    SYNC: begin
                        if (RxData == START_CODE) begin
                            count_q <= '0;
                            state_q <= DATA_HI;
                        end else if (RxData != MARK_BYTE) begin
                            state_q <= HUNT;
                        end
                    end
                    DATA_HI: begin
                        if (RxData == MARK_BYTE) begin
                            state_q <= MARK;
                        end else begin
                            hi_q    <= RxData;
                            state_q <= DATA_LO;
                        end
                    end
                    DATA_LO: begin
                        if (count_q == MAX_CNT) begin
                            // Frame overflow: drop the word and resynchronise.
                            frame_error_q <= 1'b1;
                            state_q       <= HUNT;
                        end else begin
                            word_out_q   <= {hi_q, RxData};
                            word_index_q <= count_q;
                            word_valid_q <= 1'b1;
                            count_q      <= count_q + index_t'(1);
                            state_q      <= DATA_HI;
                        end
                    end
                    MARK: begin
                        if (RxData == STOP_CODE) begin
                            frame_done_q  <= 1'b1;
                            frame_count_q <= count_q;
                            state_q       <= HUNT;
                        end else if (RxData == START_CODE) begin
                            // Unterminated frame followed by a new start: restart.
                            frame_error_q <= 1'b1;
                            count_q       <= '0;
                            state_q       <= DATA_HI;
                        end else begin
                            frame_error_q <= 1'b1;
                            state_q       <= HUNT;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign WordOut    = word_out_q;
    assign WordValid  = word_valid_q;
    assign WordIndex  = word_index_q;
    assign FrameDone  = frame_done_q;
    assign FrameCount = frame_count_q;
    assign FrameError = frame_error_q;

`ifdef PEAK_RX_MAXTRACK_EN
    logic trk_clear;
    logic trk_word;
    logic trk_commit;

    // Tracker strobes decoded from the same conditions the FSM acts on.
    always_comb begin
        trk_clear  = 1'b0;
        trk_word   = 1'b0;
        trk_commit = 1'b0;
        if (RxValid) begin
            trk_clear  = (RxData == START_CODE) && ((state_q == SYNC) || (state_q == MARK));
            trk_word   = (state_q == DATA_LO) && (count_q != MAX_CNT);
            trk_commit = (state_q == MARK) && (RxData == STOP_CODE);
        end
    end

    peak_rx_max_tracker u_max_tracker (
        .clk          (SysClk),
        .rst_n        (ResetN),
        .clear_i      (trk_clear),
        .word_valid_i (trk_word),
        .word_i       ({hi_q, RxData}),
        .index_i      (count_q),
        .commit_i     (trk_commit),
        .max_word_o   (MaxWord),
        .max_index_o  (MaxIndex)
    );
`else
    assign MaxWord  = '0;
    assign MaxIndex = '0;
`endif

endmodule

// File: tb/tb_peak_frame_receiver.sv
// Directed bench for peak_frame_receiver. Expected max values follow the
// PEAK_RX_MAXTRACK_EN build option (zero when tracking is compiled out).
module tb_peak_frame_receiver;

    logic        SysClk;
    logic        ResetN;
    logic [7:0]  RxData;
    logic        RxValid;
    logic [15:0] WordOut;
    logic        WordValid;
    logic [8:0]  WordIndex;
    logic        FrameDone;
    logic [8:0]  FrameCount;
    logic        FrameError;
    logic [15:0] MaxWord;
    logic [8:0]  MaxIndex;

    int checks = 0;
    int errors = 0;

    logic [24:0] wq[$];
    int n_done = 0;
    int n_err  = 0;
    int n_excl = 0;

    peak_frame_receiver dut (
        .SysClk     (SysClk),
        .ResetN     (ResetN),
        .RxData     (RxData),
        .RxValid    (RxValid),
        .WordOut    (WordOut),
        .WordValid  (WordValid),
        .WordIndex  (WordIndex),
        .FrameDone  (FrameDone),
        .FrameCount (FrameCount),
        .FrameError (FrameError),
        .MaxWord    (MaxWord),
        .MaxIndex   (MaxIndex)
    );

    initial SysClk = 1'b0;
    always #5 SysClk = ~SysClk;

    // Record every output event, sampled away from the rising edge.
    always @(negedge SysClk) begin
        if (WordValid) wq.push_back({WordOut, WordIndex});
        if (FrameDone) n_done++;
        if (FrameError) n_err++;
        if ((int'(WordValid) + int'(FrameDone) + int'(FrameError)) > 1) n_excl++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_max(input logic [31:0] v);
`ifdef PEAK_RX_MAXTRACK_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic send(input logic [7:0] b);
        RxData  = b;
        RxValid = 1'b1;
        @(negedge SysClk);
        RxValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge SysClk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wordout"}, 32'(WordOut), 32'd0);
        check({tag, "_wordvalid"}, 32'(WordValid), 32'd0);
        check({tag, "_wordindex"}, 32'(WordIndex), 32'd0);
        check({tag, "_framedone"}, 32'(FrameDone), 32'd0);
        check({tag, "_framecount"}, 32'(FrameCount), 32'd0);
        check({tag, "_frameerror"}, 32'(FrameError), 32'd0);
        check({tag, "_maxword"}, 32'(MaxWord), 32'd0);
        check({tag, "_maxindex"}, 32'(MaxIndex), 32'd0);
    endtask

    initial begin
        int qb;
        int db;
        int eb;
        int bad;
        logic [15:0] w;

        ResetN  = 1'b0;
        RxValid = 1'b0;
        RxData  = 8'h00;
        idle(3);
        check_zero_outputs("reset");
        ResetN = 1'b1;
        idle(2);

        // Two-word frame.
        qb = wq.size(); db = n_done; eb = n_err;
        send(8'hFF); send(8'h20); send(8'h00); send(8'h7A);
        send(8'h01); send(8'h02); send(8'hFF); send(8'h80);
        idle(3);
        check("f1_nwords", 32'(wq.size() - qb), 32'd2);
        if (wq.size() >= qb + 2) begin
            check("f1_w0", 32'(wq[qb]), {7'd0, 16'h007A, 9'd0});
            check("f1_w1", 32'(wq[qb+1]), {7'd0, 16'h0102, 9'd1});
        end
        check("f1_done", 32'(n_done - db), 32'd1);
        check("f1_err", 32'(n_err - eb), 32'd0);
        check("f1_count", 32'(FrameCount), 32'd2);
        check("f1_maxword", 32'(MaxWord), exp_max(32'h0102));
        check("f1_maxidx", 32'(MaxIndex), exp_max(32'd1));

        // Empty frame.
        qb = wq.size(); db = n_done; eb = n_err;
        send(8'hFF); send(8'h20); send(8'hFF); send(8'h80);
        idle(3);
        check("empty_nwords", 32'(wq.size() - qb), 32'd0);
        check("empty_done", 32'(n_done - db), 32'd1);
        check("empty_count", 32'(FrameCount), 32'd0);
        check("empty_maxword", 32'(MaxWord), 32'd0);

        // Leading garbage, repeated FF, and a RxValid gap between hi and lo.
        qb = wq.size(); db = n_done; eb = n_err;
        send(8'h37); send(8'hFF); send(8'hFF); send(8'h20); send(8'h12);
        idle(2);
        send(8'h34); send(8'hFF); send(8'h80);
        idle(3);
        check("gap_nwords", 32'(wq.size() - qb), 32'd1);
        if (wq.size() >= qb + 1) check("gap_w0", 32'(wq[qb]), {7'd0, 16'h1234, 9'd0});
        check("gap_done", 32'(n_done - db), 32'd1);
        check("gap_err", 32'(n_err - eb), 32'd0);
        check("gap_count", 32'(FrameCount), 32'd1);
        check("gap_maxword", 32'(MaxWord), exp_max(32'h1234));

        // Bytes outside a frame leave the frame results untouched.
        qb = wq.size(); db = n_done; eb = n_err;
        send(8'h55); send(8'hFF); send(8'h80); send(8'h00);
        idle(3);
        check("hold_count", 32'(FrameCount), 32'd1);
        check("hold_maxword", 32'(MaxWord), exp_max(32'h1234));
        check("hold_events", 32'((wq.size() - qb) + (n_done - db) + (n_err - eb)), 32'd0);

        // Restart inside a frame.
        qb = wq.size(); db = n_done; eb = n_err;
        send(8'hFF); send(8'h20); send(8'h00); send(8'h05);
        send(8'hFF); send(8'h20); send(8'h00); send(8'h06);
        send(8'hFF); send(8'h80);
        idle(3);
        check("rst_nwords", 32'(wq.size() - qb), 32'd2);
        if (wq.size() >= qb + 2) begin
            check("rst_w0", 32'(wq[qb]), {7'd0, 16'h0005, 9'd0});
            check("rst_w1", 32'(wq[qb+1]), {7'd0, 16'h0006, 9'd0});
        end
        check("rst_err", 32'(n_err - eb), 32'd1);
        check("rst_done", 32'(n_done - db), 32'd1);
        check("rst_count", 32'(FrameCount), 32'd1);
        check("rst_maxword", 32'(MaxWord), exp_max(32'h0006));
        check("rst_maxidx", 32'(MaxIndex), 32'd0);

        // Tied maximum keeps the lower index.
        qb = wq.size(); db = n_done;
        send(8'hFF); send(8'h20);
        send(8'h00); send(8'h50); send(8'h00); send(8'h90);
        send(8'h00); send(8'h90); send(8'h00); send(8'h10);
        send(8'hFF); send(8'h80);
        idle(3);
        check("tie_nwords", 32'(wq.size() - qb), 32'd4);
        check("tie_count", 32'(FrameCount), 32'd4);
        check("tie_maxword", 32'(MaxWord), exp_max(32'h0090));
        check("tie_maxidx", 32'(MaxIndex), exp_max(32'd1));

        // Overflow: MAX_WORDS+1 words, the last one is dropped with an error.
        qb = wq.size(); db = n_done; eb = n_err;
        send(8'hFF); send(8'h20);
        for (int i = 0; i <= 256; i++) begin
            w = 16'(i * 3);
            send(w[15:8]);
            send(w[7:0]);
        end
        send(8'hFF); send(8'h80);
        idle(3);
        check("ovf_nwords", 32'(wq.size() - qb), 32'd256);
        bad = 0;
        if (wq.size() >= qb + 256) begin
            for (int i = 0; i < 256; i++) begin
                if (wq[qb+i] !== {16'(i * 3), 9'(i)}) bad++;
            end
        end
        check("ovf_words_bad", 32'(bad), 32'd0);
        check("ovf_err", 32'(n_err - eb), 32'd1);
        check("ovf_done", 32'(n_done - db), 32'd0);
        check("ovf_count_held", 32'(FrameCount), 32'd4);
        check("ovf_maxword_held", 32'(MaxWord), exp_max(32'h0090));

        // Reset pulse after the third data byte, then the remainder and a new frame.
        send(8'hFF); send(8'h20); send(8'h00); send(8'h05); send(8'h01);
        ResetN = 1'b0;
        idle(2);
        check_zero_outputs("midrst");
        ResetN = 1'b1;
        idle(1);
        qb = wq.size(); db = n_done; eb = n_err;
        send(8'h02); send(8'hFF); send(8'h80);
        idle(3);
        check("remain_events", 32'((wq.size() - qb) + (n_done - db) + (n_err - eb)), 32'd0);
        send(8'hFF); send(8'h20); send(8'hAB); send(8'hCD); send(8'hFF); send(8'h80);
        idle(3);
        check("post_nwords", 32'(wq.size() - qb), 32'd1);
        if (wq.size() >= qb + 1) check("post_w0", 32'(wq[qb]), {7'd0, 16'hABCD, 9'd0});
        check("post_done", 32'(n_done - db), 32'd1);
        check("post_count", 32'(FrameCount), 32'd1);
        check("post_maxword", 32'(MaxWord), exp_max(32'hABCD));

        check("pulse_exclusive", 32'(n_excl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
